add_word_seq: RTL and testbench

//  Byte-serial multi-precision add sequencer that sits around the team's 8-bit ripple adder.

---
 rtl/add_word_seq.sv | 110 +++++++++++
 tb/tb_add_word_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/add_word_seq.sv
// add_word_seq: byte-serial multi-precision add sequencer.
// Latches two NBYTES-wide operands plus a carry-in. It then feeds one byte pair
// per cycle, LSB first, to an external combinational 8-bit adder. The adder's
// carry is chained from byte to byte, and the full-width sum is published with
// a one-cycle done pulse.
// Optional feature: define ADD_WORD_SEQ_OVF_EN to add the signed-overflow output ovf.
module add_word_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a_word,
  input  logic [8*NBYTES-1:0]   b_word,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum_word,
  output logic                  cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_z,
  input  logic                  add_cout
`ifdef ADD_WORD_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int W  = 8 * NBYTES;
  // Byte index width. $clog2 would give 0 only for NBYTES<=1, which is not a
  // legal size, but the index is kept at least 1 bit wide regardless.
  localparam int IW = (NBYTES > 2) ? $clog2(NBYTES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [NBYTES-1:0][7:0]  a_reg;
  logic [NBYTES-1:0][7:0]  b_reg;
  logic [NBYTES-1:0][7:0]  work;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    last;

  // The final byte is the one the adder is working on when idx reaches NBYTES-1.
  assign last = (idx == IW'(NBYTES - 1));

  // The adder sees the current byte pair and the chained carry directly from
  // registers. No pipeline is assumed on the adder side.
  assign add_a   = a_reg[idx];
  assign add_b   = b_reg[idx];
  assign add_cin = carry;

  // Sequencer: operands are latched on start, then one byte is processed per cycle.
  // All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_word <= '0;
      cout     <= 1'b0;
`ifdef ADD_WORD_SEQ_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_word;
            b_reg <= b_word;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work[idx] <= add_z;
          carry     <= add_cout;
          if (last) begin
            // The top byte comes straight from the adder. It is not yet in work.
            sum_word <= {add_z, work[NBYTES-2:0]};
            cout     <= add_cout;
`ifdef ADD_WORD_SEQ_OVF_EN
            // Signed overflow: the operands share a sign and the result sign differs.
            ovf      <= (a_reg[NBYTES-1][7] == b_reg[NBYTES-1][7]) &&
                        (add_z[7] != a_reg[NBYTES-1][7]);
`endif
            done     <= 1'b1;
            busy     <= 1'b0;
            idx      <= '0;
            state    <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_word_seq.sv
// Bench for add_word_seq (NBYTES=4) wired to a behavioural 8-bit adder.
// Stimulus pushes expected results into a queue. A forked monitor pops one
// entry and compares it each time the DUT presents done.
module tb_add_word_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_word = '0;
  logic [W-1:0]  b_word = '0;
  logic          cin = 1'b0;
  logic          busy, done, cout;
  logic [W-1:0]  sum_word;
  logic [7:0]    add_a, add_b, add_z;
  logic          add_cin, add_cout;
`ifdef ADD_WORD_SEQ_OVF_EN
  logic          ovf;
`endif

  // External 8-bit adder
  assign {add_cout, add_z} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  add_word_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_word(a_word), .b_word(b_word), .cin(cin),
    .busy(busy), .done(done), .sum_word(sum_word), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_z(add_z), .add_cout(add_cout)
`ifdef ADD_WORD_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Expected entry: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Wait for done, sampling 1 time unit after each edge. n counts the edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) return;
    end
    chk("done_timeout", 64'(n), 64'(NB));
  endtask

  // Issue one op and return in its done cycle, so the next op can be back-to-back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    a_word = a; b_word = b; cin = ci; start = 1'b1;
    exp_q.push_back({eo, ec, es});
    @(posedge clk); #1;
    start = 1'b0;
    a_word = $urandom; b_word = $urandom;   // free to change during RUN
    wait_done(n);
    chk("latency", 64'(n), 64'(NB));
  endtask

  initial begin
    int n;
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rc, ro;

    // Scoreboard monitor, sampling on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (done && busy) chk("done_and_busy", 64'({done, busy}), 64'(2'b10));
          if (done) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 64'(1), 64'(0));
            end else begin
              logic [W+1:0] e;
              e = exp_q.pop_front();
              chk("sum_word", 64'(sum_word), 64'(e[W-1:0]));
              chk("cout", 64'(cout), 64'(e[W]));
`ifdef ADD_WORD_SEQ_OVF_EN
              chk("ovf", 64'(ovf), 64'(e[W+1]));
`endif
            end
          end
        end
      end
    join_none

    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum_word), 64'(0));
    chk("rst_adder_in", 64'({add_a, add_b, add_cin}), 64'(0));
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // T2 carry ripple
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    // T3 carry-in, one-cycle done pulse
    run_op(32'h1234_5678, 32'h0000_FFFF, 1'b1, 32'h1235_5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_width", 64'(done), 64'(0));
    // T4 signed overflow
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // T5 start held during RUN with different operands
    a_word = 32'h0102_0304; b_word = 32'h1020_3040; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h1122_3344});
    @(posedge clk); #1;
    a_word = 32'h8000_0000; b_word = 32'h8000_0000; cin = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 32'h0000_0001});
    wait_done(n);
    chk("t5_first_latency", 64'(n), 64'(NB));
    @(posedge clk); #1;           // second op accepted in the done cycle
    start = 1'b0;
    wait_done(n);
    chk("t5_spacing", 64'(n + 1), 64'(NB + 1));

    // T1 reset mid-RUN, checked with no clock edge in between
    @(posedge clk); #1;
    a_word = 32'hDEAD_BEEF; b_word = 32'h0101_0101; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_done", 64'(done), 64'(0));
    chk("t1_sum", 64'(sum_word), 64'(0));
    chk("t1_cout", 64'(cout), 64'(0));
    chk("t1_adder_in", 64'({add_a, add_b, add_cin}), 64'(0));
`ifdef ADD_WORD_SEQ_OVF_EN
    chk("t1_ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_no_done", 64'(done), 64'(0));

    // T6 random back-to-back against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      r  = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      ro = (ra[W-1] == rb[W-1]) && (r[W-1] != ra[W-1]);
      run_op(ra, rb, rc, r[W-1:0], r[W], ro);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
